// File: rtl/rv32_operand_stage.sv
// RV32I operand-fetch stage: decodes register and ALU-immediate instructions,
// reads operands from a local register file with writeback bypass, tracks
// in-flight destinations in a scoreboard, and hands operands to the ALU over a
// valid/ready handshake. Unsupported opcodes are dropped and counted.
module rv32_operand_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   Clk,
  input  logic                   RstN,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [INSTR_WIDTH-1:0] InInstr,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [DATA_WIDTH-1:0]  AluOp1,
  output logic [DATA_WIDTH-1:0]  AluOp2,
  output logic [INSTR_WIDTH-1:0] Instr,
  output logic [4:0]             OutRd,
  input  logic                   WbValid,
  input  logic [4:0]             WbRd,
  input  logic [DATA_WIDTH-1:0]  WbData,
  output logic                   Busy,
  output logic [7:0]             DropCnt
);

  localparam logic [6:0] OP_MATH     = 7'b0110011;
  localparam logic [6:0] OP_MATH_IMM = 7'b0010011;

  logic [DATA_WIDTH-1:0] regfile [32];
  logic [31:0]           scoreboard;
  logic [31:0]           scoreboard_next;

  logic [6:0]            opcode;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [4:0]            rd;
  logic                  is_math;
  logic                  is_math_imm;
  logic                  supported;
  logic                  rs1_pending;
  logic                  rs2_pending;
  logic                  rd_pending;
  logic                  hazard;
  logic                  accept;
  logic                  issue;
  logic [DATA_WIDTH-1:0] rs1_value;
  logic [DATA_WIDTH-1:0] rs2_value;
  logic [DATA_WIDTH-1:0] imm_value;
  logic                  wb_write;

  assign opcode      = InInstr[6:0];
  assign rs1         = InInstr[19:15];
  assign rs2         = InInstr[24:20];
  assign rd          = InInstr[11:7];
  assign is_math     = (opcode == OP_MATH);
  assign is_math_imm = (opcode == OP_MATH_IMM);
  assign supported   = is_math || is_math_imm;
  assign imm_value   = {{(DATA_WIDTH-12){InInstr[31]}}, InInstr[31:20]};
  assign wb_write    = WbValid && (WbRd != 5'd0);

  // A writeback landing this cycle already resolves its scoreboard bit
  assign rs1_pending = scoreboard[rs1] && !(WbValid && (WbRd == rs1));
  assign rs2_pending = scoreboard[rs2] && !(WbValid && (WbRd == rs2));
  assign rd_pending  = scoreboard[rd]  && !(WbValid && (WbRd == rd));
  assign hazard      = supported && (rs1_pending || (is_math && rs2_pending) || rd_pending);

  assign InReady = (!OutValid || OutReady) && !hazard;
  assign accept  = InValid && InReady;
  assign issue   = accept && supported;
  assign Busy    = |scoreboard;

  // Operand read: x0 is hardwired zero, same-cycle writeback data bypasses the file
  always_comb begin
    rs1_value = regfile[rs1];
    rs2_value = regfile[rs2];
    if (rs1 == 5'd0) begin
      rs1_value = '0;
    end else if (WbValid && (WbRd == rs1)) begin
      rs1_value = WbData;
    end
    if (rs2 == 5'd0) begin
      rs2_value = '0;
    end else if (WbValid && (WbRd == rs2)) begin
      rs2_value = WbData;
    end
  end

  // Scoreboard update: writeback clears first so a same-cycle issue to that rd wins
  always_comb begin
    scoreboard_next = scoreboard;
    if (WbValid) begin
      scoreboard_next[WbRd] = 1'b0;
    end
    if (issue && (rd != 5'd0)) begin
      scoreboard_next[rd] = 1'b1;
    end
    scoreboard_next[0] = 1'b0;
  end

  // Register file write port, x0 writes are ignored
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      for (int i = 0; i < 32; i++) begin
        regfile[i] <= '0;
      end
    end else if (wb_write) begin
      regfile[WbRd] <= WbData;
    end
  end

  // Scoreboard state
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      scoreboard <= '0;
    end else begin
      scoreboard <= scoreboard_next;
    end
  end

  // Output registers: load on issue, hold while stalled, drop valid once consumed
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      OutValid <= 1'b0;
      AluOp1   <= '0;
      AluOp2   <= '0;
      Instr    <= '0;
      OutRd    <= '0;
    end else if (issue) begin
      OutValid <= 1'b1;
      AluOp1   <= rs1_value;
      AluOp2   <= is_math ? rs2_value : imm_value;
      Instr    <= InInstr;
      OutRd    <= rd;
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

  // Saturating count of discarded unsupported instructions
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      DropCnt <= '0;
    end else if (accept && !supported && (DropCnt != 8'hFF)) begin
      DropCnt <= DropCnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_rv32_operand_stage.sv
// Directed testbench for rv32_operand_stage: a table of single-cycle vectors
// with hand-computed results, followed by stall, streaming, drop-counter and
// mid-operation reset sequences.
module tb_rv32_operand_stage;

  logic        Clk;
  logic        RstN;
  logic        InValid;
  logic        InReady;
  logic [31:0] InInstr;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] AluOp1;
  logic [31:0] AluOp2;
  logic [31:0] Instr;
  logic [4:0]  OutRd;
  logic        WbValid;
  logic [4:0]  WbRd;
  logic [31:0] WbData;
  logic        Busy;
  logic [7:0]  DropCnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        in_valid;
    logic [31:0] instr;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_op1;
    logic [31:0] exp_op2;
    logic [4:0]  exp_rd;
    logic [31:0] exp_instr;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [16];

  rv32_operand_stage dut (
    .Clk      (Clk),
    .RstN     (RstN),
    .InValid  (InValid),
    .InReady  (InReady),
    .InInstr  (InInstr),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .AluOp1   (AluOp1),
    .AluOp2   (AluOp2),
    .Instr    (Instr),
    .OutRd    (OutRd),
    .WbValid  (WbValid),
    .WbRd     (WbRd),
    .WbData   (WbData),
    .Busy     (Busy),
    .DropCnt  (DropCnt)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [31:0] enc_addi(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic in_valid, input logic [31:0] instr,
                                input logic out_ready, input logic wb_valid,
                                input logic [4:0] wb_rd, input logic [31:0] wb_data);
    InValid  = in_valid;
    InInstr  = instr;
    OutReady = out_ready;
    WbValid  = wb_valid;
    WbRd     = wb_rd;
    WbData   = wb_data;
  endtask

  // Advance to one unit past the next rising edge
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
    step();
  endtask

  task automatic writeback(input logic [4:0] rd, input logic [31:0] data);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, rd, data);
    step();
  endtask

  initial begin
    int valid_seen;

    vecs[0]  = '{1'b1, 32'h00500093, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h5,        5'd1, 32'h00500093, 1'b1};
    vecs[1]  = '{1'b1, 32'h002081B3, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h5,        5'd1, 32'h00500093, 1'b1};
    vecs[2]  = '{1'b1, 32'h002081B3, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h5,        5'd1, 32'h00500093, 1'b1};
    vecs[3]  = '{1'b1, 32'h002081B3, 1'b1, 5'd1, 32'h7,        1'b1, 1'b1, 32'h7,        32'h0,        5'd3, 32'h002081B3, 1'b1};
    vecs[4]  = '{1'b1, 32'hFFF00113, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 32'h0,        32'hFFFFFFFF, 5'd2, 32'hFFF00113, 1'b1};
    vecs[5]  = '{1'b1, 32'h00108033, 1'b1, 5'd0, 32'h9,        1'b1, 1'b1, 32'h7,        32'h7,        5'd0, 32'h00108033, 1'b1};
    vecs[6]  = '{1'b1, 32'h00000233, 1'b1, 5'd3, 32'h12345678, 1'b1, 1'b1, 32'h0,        32'h0,        5'd4, 32'h00000233, 1'b1};
    vecs[7]  = '{1'b1, 32'h003182B3, 1'b1, 5'd2, 32'hA5A5A5A5, 1'b1, 1'b1, 32'h12345678, 32'h12345678, 5'd5, 32'h003182B3, 1'b1};
    vecs[8]  = '{1'b1, 32'hFFE10313, 1'b1, 5'd4, 32'h1,        1'b1, 1'b1, 32'hA5A5A5A5, 32'hFFFFFFFE, 5'd6, 32'hFFE10313, 1'b1};
    vecs[9]  = '{1'b1, 32'h004283B3, 1'b1, 5'd5, 32'h3,        1'b1, 1'b1, 32'h3,        32'h1,        5'd7, 32'h004283B3, 1'b1};
    vecs[10] = '{1'b0, 32'h0,        1'b1, 5'd6, 32'h0,        1'b1, 1'b0, 32'h3,        32'h1,        5'd7, 32'h004283B3, 1'b1};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 5'd7, 32'h55,       1'b1, 1'b0, 32'h3,        32'h1,        5'd7, 32'h004283B3, 1'b0};
    vecs[12] = '{1'b1, 32'h00638433, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 32'h55,       32'h0,        5'd8, 32'h00638433, 1'b1};
    vecs[13] = '{1'b1, 32'h00100413, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h55,       32'h0,        5'd8, 32'h00638433, 1'b1};
    vecs[14] = '{1'b1, 32'h00100413, 1'b1, 5'd8, 32'h99,       1'b1, 1'b1, 32'h0,        32'h1,        5'd8, 32'h00100413, 1'b1};
    vecs[15] = '{1'b0, 32'h0,        1'b1, 5'd8, 32'h1,        1'b1, 1'b0, 32'h0,        32'h1,        5'd8, 32'h00100413, 1'b0};

    RstN = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge Clk);
    #1;
    check_output("reset_out_valid", {31'b0, OutValid}, 32'h0);
    check_output("reset_op1", AluOp1, 32'h0);
    check_output("reset_op2", AluOp2, 32'h0);
    check_output("reset_instr", Instr, 32'h0);
    check_output("reset_rd", {27'b0, OutRd}, 32'h0);
    check_output("reset_busy", {31'b0, Busy}, 32'h0);
    check_output("reset_drop", {24'b0, DropCnt}, 32'h0);
    RstN = 1'b1;
    #2;
    check_output("reset_in_ready", {31'b0, InReady}, 32'h1);
    step();

    // Table of single-cycle vectors, OutReady held high throughout
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].in_valid, vecs[i].instr, 1'b1, vecs[i].wb_valid,
                     vecs[i].wb_rd, vecs[i].wb_data);
      #3;
      check_output($sformatf("v%0d_in_ready", i), {31'b0, InReady}, {31'b0, vecs[i].exp_ready});
      step();
      check_output($sformatf("v%0d_out_valid", i), {31'b0, OutValid}, {31'b0, vecs[i].exp_valid});
      check_output($sformatf("v%0d_op1", i), AluOp1, vecs[i].exp_op1);
      check_output($sformatf("v%0d_op2", i), AluOp2, vecs[i].exp_op2);
      check_output($sformatf("v%0d_rd", i), {27'b0, OutRd}, {27'b0, vecs[i].exp_rd});
      check_output($sformatf("v%0d_instr", i), Instr, vecs[i].exp_instr);
      check_output($sformatf("v%0d_busy", i), {31'b0, Busy}, {31'b0, vecs[i].exp_busy});
    end

    // Downstream stall: outputs hold for three cycles, then the waiting instruction issues
    apply_stimulus(1'b1, enc_addi(12'd3, 5'd0, 5'd9), 1'b1, 1'b0, 5'd0, 32'h0);
    step();
    check_output("stall_first_valid", {31'b0, OutValid}, 32'h1);
    for (int c = 0; c < 3; c++) begin
      apply_stimulus(1'b1, enc_addi(12'd4, 5'd0, 5'd10), 1'b0, 1'b0, 5'd0, 32'h0);
      #3;
      check_output($sformatf("stall%0d_in_ready", c), {31'b0, InReady}, 32'h0);
      step();
      check_output($sformatf("stall%0d_valid", c), {31'b0, OutValid}, 32'h1);
      check_output($sformatf("stall%0d_op2", c), AluOp2, 32'h3);
      check_output($sformatf("stall%0d_rd", c), {27'b0, OutRd}, 32'd9);
    end
    apply_stimulus(1'b1, enc_addi(12'd4, 5'd0, 5'd10), 1'b1, 1'b0, 5'd0, 32'h0);
    #3;
    check_output("release_in_ready", {31'b0, InReady}, 32'h1);
    step();
    check_output("release_valid", {31'b0, OutValid}, 32'h1);
    check_output("release_op2", AluOp2, 32'h4);
    check_output("release_rd", {27'b0, OutRd}, 32'd10);
    writeback(5'd9, 32'h0);
    writeback(5'd10, 32'h0);

    // Back-to-back issue at one instruction per cycle
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, enc_addi(12'(11 + k), 5'd0, 5'(11 + k)), 1'b1, 1'b0, 5'd0, 32'h0);
      #3;
      check_output($sformatf("b2b%0d_in_ready", k), {31'b0, InReady}, 32'h1);
      step();
      check_output($sformatf("b2b%0d_valid", k), {31'b0, OutValid}, 32'h1);
      check_output($sformatf("b2b%0d_op2", k), AluOp2, 32'(11 + k));
      check_output($sformatf("b2b%0d_rd", k), {27'b0, OutRd}, 32'(11 + k));
    end

    // Stream of loads: never issued, drop counter saturates at 255
    check_output("drop_start", {24'b0, DropCnt}, 32'h0);
    valid_seen = 0;
    for (int n = 0; n < 300; n++) begin
      apply_stimulus(1'b1, 32'h00002083, 1'b1, 1'b0, 5'd0, 32'h0);
      step();
      if (OutValid) valid_seen++;
      if (n == 253) check_output("drop_254", {24'b0, DropCnt}, 32'd254);
      if (n == 254) check_output("drop_255", {24'b0, DropCnt}, 32'd255);
    end
    check_output("drop_saturated", {24'b0, DropCnt}, 32'd255);
    check_output("load_no_valid", 32'(valid_seen), 32'h0);

    // Reset mid-operation with x5 pending, then a late writeback to x5
    apply_stimulus(1'b1, enc_addi(12'd7, 5'd0, 5'd5), 1'b1, 1'b0, 5'd0, 32'h0);
    step();
    check_output("pre_reset_valid", {31'b0, OutValid}, 32'h1);
    check_output("pre_reset_busy", {31'b0, Busy}, 32'h1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
    RstN = 1'b0;
    #2;
    check_output("midrst_valid", {31'b0, OutValid}, 32'h0);
    check_output("midrst_busy", {31'b0, Busy}, 32'h0);
    check_output("midrst_drop", {24'b0, DropCnt}, 32'h0);
    check_output("midrst_op2", AluOp2, 32'h0);
    check_output("midrst_instr", Instr, 32'h0);
    step();
    check_output("midrst_edge_valid", {31'b0, OutValid}, 32'h0);
    RstN = 1'b1;
    #2;
    check_output("postrst_in_ready", {31'b0, InReady}, 32'h1);
    step();
    writeback(5'd5, 32'h77);
    check_output("late_wb_busy", {31'b0, Busy}, 32'h0);
    apply_stimulus(1'b1, 32'h000280B3, 1'b1, 1'b0, 5'd0, 32'h0);
    step();
    check_output("late_wb_valid", {31'b0, OutValid}, 32'h1);
    check_output("late_wb_op1", AluOp1, 32'h77);
    check_output("late_wb_rd", {27'b0, OutRd}, 32'd1);
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32_operand_stage.md
RV32_OPERAND_STAGE -- requirements
Module: rv32_operand_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/register width.
REQ-002 Parameter INSTR_WIDTH, default 32, instruction width.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 RstN  input  1  reset, asynchronous, active-low.
REQ-005 InValid  input  1  upstream instruction valid.
REQ-006 InReady  output  1  stage accepts InInstr this cycle.
REQ-007 InInstr  input  INSTR_WIDTH  raw RV32I instruction.
REQ-008 OutValid  output  1  AluOp1/AluOp2/Instr/OutRd valid to ALU.
REQ-009 OutReady  input  1  downstream consumes the output this cycle.
REQ-010 AluOp1  output  DATA_WIDTH  rs1 value.
REQ-011 AluOp2  output  DATA_WIDTH  rs2 value (OP_MATH) or sign-extended Imm[11:0] (OP_MATH_IMM).
REQ-012 Instr  output  INSTR_WIDTH  registered copy of the issued instruction.
REQ-013 OutRd  output  5  destination register of the issued instruction.
REQ-014 WbValid  input  1  ALU result writeback strobe.
REQ-015 WbRd  input  5  writeback destination.
REQ-016 WbData  input  DATA_WIDTH  writeback value (AluOut).
REQ-017 Busy  output  1  high while any scoreboard bit is set.
REQ-018 DropCnt  output  8  count of discarded unsupported instructions, saturating at 255.

Function
REQ-019 The block SHALL hold a 32 x DATA_WIDTH register file; x0 SHALL read as 0, and writes to x0 SHALL be ignored.
REQ-020 Decode: rs1=Instr[19:15], rs2=Instr[24:20], rd=Instr[11:7], opcode=Instr[6:0]; only OP_MATH (0110011) and OP_MATH_IMM (0010011) are supported.
REQ-021 A 32-bit scoreboard SHALL mark each rd with an issued but not yet written-back result; bit 0 SHALL always be 0.
REQ-022 Hazard: asserted for a supported instruction when rs1 is pending, when rs2 is pending (OP_MATH only), or when rd is pending; a pending bit cleared by a same-cycle WbValid with matching WbRd SHALL NOT count as pending.
REQ-023 InReady SHALL equal (!OutValid || OutReady) && !Hazard; unsupported opcodes never raise Hazard.
REQ-024 Accept = InValid && InReady; on accepting a supported instruction, the output registers SHALL load the operands, Instr, and rd, and OutValid SHALL be 1 on the next cycle (latency 1).
REQ-025 On accepting an unsupported opcode, the block SHALL discard the instruction, SHALL NOT change OutValid or the scoreboard, and SHALL increment DropCnt, saturating at 255.
REQ-026 Bypass: when WbValid, WbRd==rs (rs!=0), and an operand is captured in the same cycle, the captured value SHALL be WbData, not the file contents.
REQ-027 On WbValid with WbRd!=0, the block SHALL write regfile[WbRd]=WbData and clear scoreboard[WbRd], whether or not that bit was set.
REQ-028 Same-cycle issue setting bit rd and writeback clearing the same bit: the set SHALL win.
REQ-029 When OutValid && !OutReady, all output registers SHALL hold stable; when OutValid && OutReady with no accept, OutValid SHALL drop to 0 on the next cycle.
REQ-030 Back-to-back issue SHALL sustain one instruction per cycle when hazard-free and OutReady=1.
REQ-031 Busy SHALL be the OR of all scoreboard bits, registered state only.

Reset
REQ-032 While RstN=0: OutValid=0, AluOp1=AluOp2=0, Instr=0, OutRd=0, scoreboard=0, DropCnt=0, all registers=0.
REQ-033 Reset asserted mid-operation SHALL abandon in-flight outputs; writebacks for pre-reset issues that arrive after reset SHALL still write the file without error.
REQ-034 InReady SHALL be 1 out of reset provided no hazard exists.

Verification
REQ-035 Reset, then issue ADDI x1,x0,5 (0x00500093) -> next cycle OutValid=1, AluOp1=0, AluOp2=5, OutRd=1, Busy=1.
REQ-036 Issue ADD x3,x1,x2 while x1 pending -> InReady=0 until WbValid, WbRd=1, WbData=7, then issue with AluOp1=7 in that cycle via bypass.
REQ-037 ADDI x2,x0,-1 (0xFFF00113) -> AluOp2=0xFFFFFFFF; ADD x0,x1,x1 -> OutRd=0, scoreboard unchanged, and a write of 9 to x0 reads back 0.
REQ-038 OutReady held 0 for 3 cycles with OutValid=1 -> outputs stable and InReady=0; release -> next instruction accepted.
REQ-039 Stream 300 loads (opcode 0000011) -> no OutValid, DropCnt=255.
REQ-040 Assert RstN=0 with OutValid=1 and x5 pending -> next edge OutValid=0, Busy=0, DropCnt=0.
